ad9958_sweep_gen: RTL and testbench
===================================

# ad9958_sweep_gen

Frequency/amplitude sweep generator sitting directly upstream of the AD9958 serial master. It produces the four 32-bit tuning words (`ftw_ch0`, `ftw_ch1`, `asf_ch0`, `asf_ch1`) that the master continuously serialises. Channel 0 ramps linearly from a start to a stop tuning word with a programmable dwell per step. Channel 1 tracks channel 0 at a fixed frequency offset.

## Interface
- `DWELL_W`, 24, width of dwell counter/input (cycles per frequency point).
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a sweep; config sampled on acceptance.
- `abort`  in  1  terminate sweep immediately.
- `loop`  in  1  0 = single sweep, 1 = continuous.
- `ftw_start`  in  32  first channel-0 tuning word.
- `ftw_stop`  in  32  last channel-0 tuning word.
- `ftw_step`  in  32  increment per point.
- `ftw_offset`  in  32  channel-1 offset added to channel 0.
- `amp_ch0`, `amp_ch1`  in  10  amplitude scale factors.
- `dwell`  in  DWELL_W  cycles each point is held.
- `ftw_ch0`, `ftw_ch1`, `asf_ch0`, `asf_ch1`  out  32  words to the serial master.
- `busy`  out  1  sweep in progress.
- `step_strobe`  out  1  one-cycle pulse on every output value change.
- `done`  out  1  one-cycle pulse at end of a single sweep.

## Operation
- States: IDLE, DWELL, DONE. Reset enters IDLE.
- `start` is accepted in IDLE or DONE only. It is ignored in DWELL. On acceptance:
  - Latch all config inputs.
  - Load `ftw_ch0 = ftw_start`.
  - Assert `step_strobe`.
  - Load the dwell counter and enter DWELL.
- `dwell = 0` is treated as 1.
- `asf_chN = {19'd0, 1'b1, 2'd0, amp_chN}`: bit 12 is the multiplier enable and bits [9:0] are the amplitude. These outputs update only on start acceptance.
- `ftw_ch1 = ftw_ch0 + ftw_offset` mod 2^32. It updates in the same cycle as `ftw_ch0`.
- DWELL: the counter decrements each cycle. At expiry, compute `next = cur + step` in 33 bits.
  - If `cur == stop`, or `step == 0`, or `start > stop`, the sweep has ended:
    - `loop = 0`: pulse `done`, go to DONE, and hold outputs.
    - `loop = 1`: reload `ftw_start` and pulse `step_strobe`. The exception is `step == 0` or `start > stop`, which always goes to DONE.
  - Else if `next > stop` or carry set: output `stop` (clamp).
  - Else: output `next`.
  - Every new value pulses `step_strobe` and reloads the counter.
- `abort` in any state: go to IDLE, hold outputs, no `done`. If `abort` and `start` occur in the same cycle, `abort` wins.
- `busy = 1` exactly while in DWELL.

## Timing
- Reset values: every 32-bit output 0; `busy`, `step_strobe`, `done` all 0.
- `start` is sampled at edge k. New outputs, `busy = 1` and `step_strobe` are visible after edge k.
- Each point is held exactly `dwell` cycles. `step_strobe` pulses are spaced `dwell` cycles apart.
- The final point is held `dwell` cycles. `done` then asserts for one cycle in the same cycle `busy` falls.
- Restart from DONE: `start` may arrive in the cycle after `done`.
- Reset mid-sweep: asynchronous return to reset values. No `done` is issued.

## Configuration
- `AD9958_SWEEP_TRIANGLE_EN` defined, with `loop = 1`: triangle sweep.
  - On reaching `stop`, direction reverses and the value decrements by `step`, clamped at `start` (underflow checked in 33 bits). It reverses again at `start`.
  - Endpoints are emitted once per turn and are not repeated.
  - Single-sweep behaviour is unchanged.
- Not defined: `loop = 1` is a sawtooth (wrap to `ftw_start`). The direction state and decrement path are absent.

## Test plan
- Single sweep: start=100, step=10, stop=130, dwell=4.
  - Required: `ftw_ch0` = 100, 110, 120, 130, each held 4 cycles.
  - Required: `done` pulse 16 cycles after the first value appears; then `busy = 0` and 130 is held.
- Clamp: start=0, step=30, stop=100, dwell=1.
  - Required: sequence 0, 30, 60, 90, 100, then `done`.
  - Repeat with start=0xFFFFFFE0, step=0x40, stop=0xFFFFFFFF: required sequence 0xFFFFFFE0, 0xFFFFFFFF.
- Offset wrap: ftw_start=stop=0xFFFFFFF0, offset=0x20, amp_ch0=0x3FF.
  - Required: `ftw_ch1` = 0x10, `asf_ch0` = 0x000013FF.
  - Required: one-point sweep, `done` after `dwell` cycles.
- Loop sawtooth: start=0, step=10, stop=20, dwell=2.
  - Required: 0, 10, 20, 0, 10 …, `step_strobe` every 2 cycles, `done` never asserted.
  - With the macro defined, required: 0, 10, 20, 10, 0, 10, 20 ….
- Control hazards:
  - `start` while busy: ignored, sequence unaffected.
  - `abort` at the 2nd point: `busy` falls next cycle, outputs hold 10, no `done`.
  - `abort` and `start` in the same cycle: remain in IDLE.
  - `reset_n` low mid-sweep: all outputs 0 immediately.

Source files
------------

// File: rtl/ad9958_sweep_gen_if.sv
// Control, configuration and tuning-word bundle between the sweep generator and its host.
// The master side drives control and configuration; the slave side returns the words and status.
interface ad9958_sweep_gen_if #(
  parameter int DWELL_W = 24
);
  logic               start;
  logic               abort;
  logic               loop;
  logic [31:0]        ftw_start;
  logic [31:0]        ftw_stop;
  logic [31:0]        ftw_step;
  logic [31:0]        ftw_offset;
  logic [9:0]         amp_ch0;
  logic [9:0]         amp_ch1;
  logic [DWELL_W-1:0] dwell;
  logic [31:0]        ftw_ch0;
  logic [31:0]        ftw_ch1;
  logic [31:0]        asf_ch0;
  logic [31:0]        asf_ch1;
  logic               busy;
  logic               step_strobe;
  logic               done;

  modport master (
    output start, abort, loop, ftw_start, ftw_stop, ftw_step, ftw_offset,
           amp_ch0, amp_ch1, dwell,
    input  ftw_ch0, ftw_ch1, asf_ch0, asf_ch1, busy, step_strobe, done
  );

  modport slave (
    input  start, abort, loop, ftw_start, ftw_stop, ftw_step, ftw_offset,
           amp_ch0, amp_ch1, dwell,
    output ftw_ch0, ftw_ch1, asf_ch0, asf_ch1, busy, step_strobe, done
  );
endinterface

// File: rtl/ad9958_sweep_gen.sv
// Linear frequency sweep generator producing the AD9958 channel tuning words.
// Define AD9958_SWEEP_TRIANGLE_EN to make looped sweeps bounce between start and stop.
module ad9958_sweep_gen #(
  parameter int DWELL_W = 24
) (
  input logic               clock,
  input logic               reset_n,
  ad9958_sweep_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [31:0]        cur_r, ftw_ch1_r, asf_ch0_r, asf_ch1_r;
  logic [31:0]        cfg_start_r, cfg_stop_r, cfg_step_r, cfg_offset_r;
  logic               cfg_loop_r;
  logic [DWELL_W-1:0] cfg_dwell_r, cnt_r;
  logic               busy_r, strobe_r, done_r;

  logic               accept_s, expire_s, degenerate_s, at_stop_s, finish_s;
  logic [DWELL_W-1:0] dwell_norm_s, cnt_nxt_s;
  logic [32:0]        sum_s;
  logic [31:0]        up_val_s, step_val_s, cur_nxt_s;
  logic               strobe_nxt_s, done_nxt_s;
`ifdef AD9958_SWEEP_TRIANGLE_EN
  logic               dir_dn_r, dir_dn_step_s, dir_dn_nxt_s;
  logic [32:0]        diff_s;
  logic [31:0]        dn_val_s;
`endif

  function automatic logic [31:0] asf_word(input logic [9:0] amp);
    return {19'd0, 1'b1, 2'd0, amp};
  endfunction

  assign accept_s     = bus.start & ~bus.abort & (state_r != DWELL);
  assign expire_s     = (state_r == DWELL) & (cnt_r == DWELL_W'(1));
  assign degenerate_s = (cfg_step_r == 32'd0) | (cfg_start_r > cfg_stop_r);
  assign at_stop_s    = (cur_r == cfg_stop_r);
  assign finish_s     = expire_s & (degenerate_s | (at_stop_s & ~cfg_loop_r));
  assign dwell_norm_s = (bus.dwell == {DWELL_W{1'b0}}) ? DWELL_W'(1) : bus.dwell;
  // Carry out of the 33-bit sum means the step ran past 2^32 and must clamp too.
  assign sum_s        = {1'b0, cur_r} + {1'b0, cfg_step_r};
  assign up_val_s     = (sum_s > {1'b0, cfg_stop_r}) ? cfg_stop_r : sum_s[31:0];

`ifdef AD9958_SWEEP_TRIANGLE_EN
  assign diff_s   = {1'b0, cur_r} - {1'b0, cfg_step_r};
  assign dn_val_s = (diff_s[32] | (diff_s[31:0] < cfg_start_r)) ? cfg_start_r : diff_s[31:0];

  // Next point of a triangle sweep; direction flips on the endpoint itself so it is not repeated.
  always_comb begin
    step_val_s    = up_val_s;
    dir_dn_step_s = dir_dn_r;
    if (!dir_dn_r) begin
      if (at_stop_s) begin
        step_val_s    = dn_val_s;
        dir_dn_step_s = 1'b1;
      end else begin
        step_val_s    = up_val_s;
        dir_dn_step_s = 1'b0;
      end
    end else begin
      if (cur_r == cfg_start_r) begin
        step_val_s    = up_val_s;
        dir_dn_step_s = 1'b0;
      end else begin
        step_val_s    = dn_val_s;
        dir_dn_step_s = 1'b1;
      end
    end
  end
`else
  // Next point of a sawtooth sweep: wrap to start once stop has been held.
  always_comb begin
    step_val_s = up_val_s;
    if (at_stop_s) begin
      step_val_s = cfg_start_r;
    end else begin
      step_val_s = up_val_s;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides everything including a coincident start.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.abort) begin
      state_nxt_s = IDLE;
    end else if (accept_s) begin
      state_nxt_s = DWELL;
    end else if (finish_s) begin
      state_nxt_s = DONE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output logic: next tuning word, dwell count and pulse values.
  always_comb begin
    cur_nxt_s    = cur_r;
    cnt_nxt_s    = cnt_r;
    strobe_nxt_s = 1'b0;
    done_nxt_s   = 1'b0;
`ifdef AD9958_SWEEP_TRIANGLE_EN
    dir_dn_nxt_s = dir_dn_r;
`endif
    if (bus.abort) begin
      cur_nxt_s = cur_r;
    end else if (accept_s) begin
      cur_nxt_s    = bus.ftw_start;
      cnt_nxt_s    = dwell_norm_s;
      strobe_nxt_s = 1'b1;
`ifdef AD9958_SWEEP_TRIANGLE_EN
      dir_dn_nxt_s = 1'b0;
`endif
    end else if (state_r == DWELL) begin
      if (!expire_s) begin
        cnt_nxt_s = cnt_r - DWELL_W'(1);
      end else if (finish_s) begin
        done_nxt_s = 1'b1;
      end else begin
        cur_nxt_s    = step_val_s;
        cnt_nxt_s    = cfg_dwell_r;
        strobe_nxt_s = 1'b1;
`ifdef AD9958_SWEEP_TRIANGLE_EN
        dir_dn_nxt_s = dir_dn_step_s;
`endif
      end
    end else begin
      cur_nxt_s = cur_r;
    end
  end

  // Output and configuration registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_r        <= 32'd0;
      ftw_ch1_r    <= 32'd0;
      asf_ch0_r    <= 32'd0;
      asf_ch1_r    <= 32'd0;
      cfg_start_r  <= 32'd0;
      cfg_stop_r   <= 32'd0;
      cfg_step_r   <= 32'd0;
      cfg_offset_r <= 32'd0;
      cfg_loop_r   <= 1'b0;
      cfg_dwell_r  <= {DWELL_W{1'b0}};
      cnt_r        <= {DWELL_W{1'b0}};
      busy_r       <= 1'b0;
      strobe_r     <= 1'b0;
      done_r       <= 1'b0;
`ifdef AD9958_SWEEP_TRIANGLE_EN
      dir_dn_r     <= 1'b0;
`endif
    end else begin
      cur_r    <= cur_nxt_s;
      cnt_r    <= cnt_nxt_s;
      strobe_r <= strobe_nxt_s;
      done_r   <= done_nxt_s;
      busy_r   <= (state_nxt_s == DWELL);
`ifdef AD9958_SWEEP_TRIANGLE_EN
      dir_dn_r <= dir_dn_nxt_s;
`endif
      if (accept_s) begin
        cfg_start_r  <= bus.ftw_start;
        cfg_stop_r   <= bus.ftw_stop;
        cfg_step_r   <= bus.ftw_step;
        cfg_offset_r <= bus.ftw_offset;
        cfg_loop_r   <= bus.loop;
        cfg_dwell_r  <= dwell_norm_s;
        asf_ch0_r    <= asf_word(bus.amp_ch0);
        asf_ch1_r    <= asf_word(bus.amp_ch1);
        ftw_ch1_r    <= bus.ftw_start + bus.ftw_offset;
      end else begin
        ftw_ch1_r    <= cur_nxt_s + cfg_offset_r;
      end
    end
  end

  assign bus.ftw_ch0     = cur_r;
  assign bus.ftw_ch1     = ftw_ch1_r;
  assign bus.asf_ch0     = asf_ch0_r;
  assign bus.asf_ch1     = asf_ch1_r;
  assign bus.busy        = busy_r;
  assign bus.step_strobe = strobe_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_ad9958_sweep_gen.sv
// Scoreboard bench for ad9958_sweep_gen: a reference model queues every expected strobe/done
// event, and a negedge monitor pops and compares them as the DUT presents them.
module tb_ad9958_sweep_gen;
  localparam int DWELL_W = 24;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  ad9958_sweep_gen_if #(.DWELL_W(DWELL_W)) bus ();
  ad9958_sweep_gen #(.DWELL_W(DWELL_W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  typedef struct {
    bit          is_done;
    logic [31:0] f0, f1, a0, a1;
    int          gap;
  } exp_t;

  typedef struct {
    logic [31:0] s, e, st, off;
    logic [9:0]  a0, a1;
    int          dw;
    bit          lp;
  } cfg_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_strobe = 0;

  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset_n === 1'b1 && (bus.step_strobe === 1'b1 || bus.done === 1'b1)) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: strobe=%0b done=%0b ftw_ch0=%h, required no event",
                   bus.step_strobe, bus.done, bus.ftw_ch0);
        end else begin
          e  = sb_q.pop_front();
          ok = (bus.done === e.is_done) && (bus.step_strobe === !e.is_done) &&
               (bus.busy === !e.is_done) && (bus.ftw_ch0 === e.f0) && (bus.ftw_ch1 === e.f1) &&
               (bus.asf_ch0 === e.a0) && (bus.asf_ch1 === e.a1) &&
               (e.gap == 0 || (cyc - last_strobe) == e.gap);
          if (!ok) begin
            bad++;
            $display("FAIL sb_event: got done=%0b strobe=%0b busy=%0b ch0=%h ch1=%h asf0=%h asf1=%h gap=%0d, required done=%0b ch0=%h ch1=%h asf0=%h asf1=%h gap=%0d",
                     bus.done, bus.step_strobe, bus.busy, bus.ftw_ch0, bus.ftw_ch1, bus.asf_ch0,
                     bus.asf_ch1, cyc - last_strobe, e.is_done, e.f0, e.f1, e.a0, e.a1, e.gap);
          end
        end
        last_strobe = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
  endtask

  task automatic apply_cfg(input cfg_t c);
    bus.ftw_start  = c.s;
    bus.ftw_stop   = c.e;
    bus.ftw_step   = c.st;
    bus.ftw_offset = c.off;
    bus.amp_ch0    = c.a0;
    bus.amp_ch1    = c.a1;
    bus.dwell      = DWELL_W'(c.dw);
    bus.loop       = c.lp;
  endtask

  function automatic cfg_t mk(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                              input logic [31:0] off, input logic [9:0] a0, input logic [9:0] a1,
                              input int dw, input bit lp);
    cfg_t c;
    c.s = s; c.e = e; c.st = st; c.off = off; c.a0 = a0; c.a1 = a1; c.dw = dw; c.lp = lp;
    return c;
  endfunction

  function automatic cfg_t rnd_cfg(input bit lp);
    cfg_t        c;
    logic [31:0] span;
    c.s  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255)) : $urandom;
    span = $urandom_range(0, 150);
    c.e  = c.s + span;
    if ($urandom_range(0, 7) == 0) c.e = c.s - 32'd1 - span;
    c.st  = $urandom_range(0, 40);
    c.off = $urandom;
    c.a0  = 10'($urandom_range(0, 1023));
    c.a1  = 10'($urandom_range(0, 1023));
    c.dw  = lp ? int'($urandom_range(2, 4)) : int'($urandom_range(0, 4));
    c.lp  = lp;
    return c;
  endfunction

  // Next point from the sweep rules, using wide signed arithmetic with min/max clamping.
  function automatic void next_pt(input cfg_t c, input longint v, input bit up,
                                  output longint nv, output bit nup);
    longint lo, hi, st;
    lo  = {32'd0, c.s};
    hi  = {32'd0, c.e};
    st  = {32'd0, c.st};
    nup = up;
    nv  = v;
`ifdef AD9958_SWEEP_TRIANGLE_EN
    if (c.lp && up && v == hi) nup = 1'b0;
    else if (c.lp && !up && v == lo) nup = 1'b1;
    if (nup) nv = (v + st > hi) ? hi : v + st;
    else nv = (v - st < lo) ? lo : v - st;
`else
    if (v == hi) nv = lo;
    else nv = (v + st > hi) ? hi : v + st;
`endif
  endfunction

  // Queue the expected events of a sweep: every point, then done if it ends; npts>0 caps the points.
  task automatic push_sweep(input cfg_t c, input int npts, output logic [31:0] last);
    longint v, nv;
    bit     up, nup, ended;
    int     n, dw;
    exp_t   e;
    dw   = (c.dw == 0) ? 1 : c.dw;
    v    = {32'd0, c.s};
    up   = 1'b1;
    n    = 0;
    e.a0 = 32'h0000_1000 | {22'd0, c.a0};
    e.a1 = 32'h0000_1000 | {22'd0, c.a1};
    last = c.s;
    forever begin
      e.is_done = 1'b0;
      e.f0      = v[31:0];
      e.f1      = v[31:0] + c.off;
      e.gap     = (n == 0) ? 0 : dw;
      sb_q.push_back(e);
      n++;
      last  = v[31:0];
      ended = (c.st == 32'd0) || (c.s > c.e) || (!c.lp && v == {32'd0, c.e});
      if (ended) begin
        e.is_done = 1'b1;
        e.gap     = dw;
        sb_q.push_back(e);
        break;
      end
      if (npts > 0 && n >= npts) break;
      next_pt(c, v, up, nv, nup);
      v  = nv;
      up = nup;
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected events pending after %0d cycles, required 0", name,
               sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic run_single(input string name, input cfg_t c);
    logic [31:0] last;
    apply_cfg(c);
    push_sweep(c, 0, last);
    pulse_start();
    wait_empty(name, 5000);
    tick(2);
    check({name, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    check({name, "_hold"}, bus.ftw_ch0, last);
  endtask

  task automatic run_loop(input string name, input cfg_t c, input int npts);
    logic [31:0] last;
    apply_cfg(c);
    push_sweep(c, npts, last);
    pulse_start();
    wait_empty(name, 5000);
    pulse_abort();
    check({name, "_busy_abort"}, {31'd0, bus.busy}, 32'd0);
    check({name, "_hold_abort"}, bus.ftw_ch0, last);
    tick(10);
  endtask

  initial begin : stimulus
    cfg_t        c;
    logic [31:0] last;
    int          k;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.loop       = 1'b0;
    bus.ftw_start  = 32'd0;
    bus.ftw_stop   = 32'd0;
    bus.ftw_step   = 32'd0;
    bus.ftw_offset = 32'd0;
    bus.amp_ch0    = 10'd0;
    bus.amp_ch1    = 10'd0;
    bus.dwell      = {DWELL_W{1'b0}};
    tick(3);
    check("rst_ftw_ch0", bus.ftw_ch0, 32'd0);
    check("rst_ftw_ch1", bus.ftw_ch1, 32'd0);
    check("rst_asf_ch0", bus.asf_ch0, 32'd0);
    check("rst_asf_ch1", bus.asf_ch1, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_strobe", {31'd0, bus.step_strobe}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    run_single("single", mk(32'd100, 32'd130, 32'd10, 32'd0, 10'h155, 10'h0AA, 4, 1'b0));
    run_single("clamp", mk(32'd0, 32'd100, 32'd30, 32'd0, 10'h001, 10'h200, 1, 1'b0));
    run_single("clamp_top", mk(32'hFFFF_FFE0, 32'hFFFF_FFFF, 32'h40, 32'h1234, 10'h07F, 10'h300, 1, 1'b0));
    run_single("offset_wrap", mk(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd5, 32'h20, 10'h3FF, 10'h001, 3, 1'b0));
    check("offset_wrap_ch1", bus.ftw_ch1, 32'h0000_0010);
    check("offset_wrap_asf0", bus.asf_ch0, 32'h0000_13FF);
    run_single("dwell_zero", mk(32'd7, 32'd9, 32'd1, 32'd3, 10'h011, 10'h022, 0, 1'b0));

    // start while busy must not disturb the running sweep
    c = mk(32'd0, 32'd40, 32'd10, 32'd7, 10'h010, 10'h020, 3, 1'b0);
    apply_cfg(c);
    push_sweep(c, 0, last);
    pulse_start();
    tick(4);
    apply_cfg(mk(32'd500, 32'd900, 32'd1, 32'd9, 10'h3AA, 10'h155, 1, 1'b0));
    pulse_start();
    wait_empty("start_busy", 500);
    tick(2);
    check("start_busy_hold", bus.ftw_ch0, last);

    // restart in the cycle right after done
    c = mk(32'd5, 32'd25, 32'd10, 32'd1, 10'h0F0, 10'h00F, 2, 1'b0);
    apply_cfg(c);
    push_sweep(c, 0, last);
    pulse_start();
    k = 0;
    while (bus.done !== 1'b1 && k < 500) begin
      tick(1);
      k++;
    end
    check("restart_done_seen", {31'd0, bus.done}, 32'd1);
    c = mk(32'd50, 32'd70, 32'd7, 32'd2, 10'h111, 10'h222, 2, 1'b0);
    apply_cfg(c);
    push_sweep(c, 0, last);
    pulse_start();
    wait_empty("restart", 500);
    tick(2);

    run_loop("loop_saw", mk(32'd0, 32'd20, 32'd10, 32'd0, 10'h123, 10'h321, 2, 1'b1), 9);

    // abort at the second point
    c = mk(32'd0, 32'd40, 32'd10, 32'd0, 10'h005, 10'h006, 4, 1'b0);
    apply_cfg(c);
    push_sweep(c, 2, last);
    pulse_start();
    wait_empty("abort2", 500);
    pulse_abort();
    check("abort2_busy", {31'd0, bus.busy}, 32'd0);
    check("abort2_hold", bus.ftw_ch0, 32'd10);
    tick(10);

    // abort and start together stay idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy", {31'd0, bus.busy}, 32'd0);
    tick(5);
    check("abort_start_busy_later", {31'd0, bus.busy}, 32'd0);
    check("abort_start_hold", bus.ftw_ch0, 32'd10);

    // reset in the middle of a sweep
    c = mk(32'd1000, 32'd2000, 32'd100, 32'h55, 10'h2AA, 10'h155, 3, 1'b0);
    apply_cfg(c);
    push_sweep(c, 2, last);
    pulse_start();
    wait_empty("mid_reset", 500);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ftw_ch0", bus.ftw_ch0, 32'd0);
    check("mid_rst_ftw_ch1", bus.ftw_ch1, 32'd0);
    check("mid_rst_asf_ch0", bus.asf_ch0, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(5);

    for (int i = 0; i < 12; i++) run_single("rnd_single", rnd_cfg(1'b0));
    for (int i = 0; i < 4; i++) run_loop("rnd_loop", rnd_cfg(1'b1), int'($urandom_range(3, 10)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
